hex_char_formatter: RTL and testbench
=====================================

// Module: hex_char_formatter
// PURPOSE
//   Turns a WIDTH-bit word into a stream of ASCII hex characters, MS nibble first, one char per handshake.
//   Optional per-nibble zero mask gives "{hi, 4'd0, lo}"-style output without rebuilding the word.
//   Downstream of a word producer; feeds the character sink that prints lines such as "abcd=" / "ab0d=".
// PARAMETERS
//   WIDTH      16  data width in bits; multiple of 4, >= 4; NIB = WIDTH/4 characters per word
//   LOWERCASE  1   1: digits a-f encoded 0x61-0x66; 0: A-F encoded 0x41-0x46
// PORTS
//   clk        in   1        single clock; all state updates on posedge
//   rst        in   1        asynchronous, active-high reset
//   in_valid   in   1        in_data/in_mask valid
//   in_ready   out  1        formatter idle, can accept a word
//   in_data    in   WIDTH    word to format
//   in_mask    in   NIB      bit i set -> nibble i (bits 4i+3:4i) printed as '0'
//   out_valid  out  1        out_char valid
//   out_ready  in   1        sink accepts out_char
//   out_char   out  8        ASCII character
//   out_last   out  1        marks final character of the word
//   busy       out  1        word in progress (== !in_ready)
// BEHAVIOUR
//   - Reset (async assert, sync-safe release): state IDLE; in_ready=1, busy=0, out_valid=0,
//     out_char=8'h00, out_last=0; captured word and nibble index cleared.
//   - States: IDLE -> EMIT (-> NL with HEXFMT_NEWLINE_EN) -> IDLE.
//   - IDLE: in_valid&&in_ready at edge N captures (in_data & ~expanded mask); index=NIB-1; go EMIT.
//     First char valid at N+1 (1-cycle latency). in_ready=0 from N+1 until the word completes.
//   - EMIT: out_char = ASCII of nibble[index]; 0-9 -> 0x30-0x39; 10-15 per LOWERCASE.
//     On out_valid&&out_ready: index>0 -> index-1, next char valid next cycle (no bubble);
//     index==0 -> IDLE (or NL). in_ready returns 1 the cycle after the final handshake.
//   - Output registered; out_char/out_last stable while out_valid && !out_ready; out_valid never
//     drops without a handshake. out_ready ignored when out_valid=0.
//   - out_last=1 only with the final character (index 0, or '\n' in NL); 0 otherwise.
//   - Throughput: NIB (+1) chars per word, 1 idle cycle between words; in_valid while busy is held off.
//   - Mask: all ones -> NIB '0' chars; mask ignored for bits outside NIB; mask sampled only at capture.
//   - Reset mid-word: sequence aborted immediately, no out_last issued; next word starts fresh.
//   - Input changes after capture have no effect on the word in flight.
// CONFIGURATION
//   HEXFMT_NEWLINE_EN defined: after nibble 0 handshake go NL; emit 8'h0A with out_last=1;
//     out_last is NOT set on the last hex digit; NIB+1 chars per word.
//   Not defined: NL state absent; out_last on last hex digit; exactly NIB chars per word.
// TESTING
//   1. WIDTH=16, LOWERCASE=1, out_ready=1: in_data=16'habcd, mask=0 -> 0x61,0x62,0x63,0x64 on 4 consecutive cycles, out_last on 0x64.
//   2. in_data=16'habcd, in_mask=4'b0010 -> "ab0d" (0x61,0x62,0x30,0x64); mask=4'b1111 -> "0000".
//   3. Backpressure: out_ready low 3 cycles on 2nd char -> 0x62 held steady, out_valid stays 1, order intact.
//   4. Back-to-back words 16'h1234 then 16'hffff (LOWERCASE=0) -> "1234" then "FFFF"; in_ready low while busy, 1 idle cycle gap.
//   5. Assert rst after 2nd char of 16'habcd -> out_valid=0, in_ready=1 async; next word 16'h00ff -> "00ff" complete.
//   6. With HEXFMT_NEWLINE_EN: 16'habcd -> 5 chars, out_last only on 8'h0A; without macro -> 4 chars.

Source files
------------

// File: rtl/hex_char_formatter_if.sv
// ---------------------------------------------------------------------------
// hex_char_formatter_if
//   Groups the word-in / char-out handshakes of hex_char_formatter.
//   Parameter WIDTH is the data word width (multiple of 4); NIB = WIDTH/4.
//
//   Signals
//     in_valid   producer -> formatter  in_data/in_mask valid
//     in_ready   formatter -> producer  formatter idle, can accept a word
//     in_data    producer -> formatter  word to format (WIDTH bits)
//     in_mask    producer -> formatter  bit i set -> nibble i printed as '0'
//     out_valid  formatter -> sink      out_char valid
//     out_ready  sink -> formatter      sink accepts out_char
//     out_char   formatter -> sink      ASCII character
//     out_last   formatter -> sink      final character of the word
//     busy       formatter -> observer  word in progress (== !in_ready)
//
//   Modports
//     master : the environment side (word producer + character sink)
//     slave  : the formatter side
// ---------------------------------------------------------------------------
interface hex_char_formatter_if #(
    parameter int WIDTH = 16
);
    localparam int NIB = WIDTH / 4;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [NIB-1:0]   in_mask;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_char;
    logic             out_last;
    logic             busy;

    modport master (
        output in_valid, in_data, in_mask, out_ready,
        input  in_ready, out_valid, out_char, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, in_mask, out_ready,
        output in_ready, out_valid, out_char, out_last, busy
    );
endinterface

// File: rtl/hex_char_formatter.sv
// ---------------------------------------------------------------------------
// hex_char_formatter
//   Converts a WIDTH-bit word into a stream of ASCII hex characters, most
//   significant nibble first, one character per out_valid/out_ready
//   handshake. A per-nibble mask forces selected nibbles to print as '0'.
//
//   Parameters
//     WIDTH      data width in bits (multiple of 4, >= 4); NIB = WIDTH/4
//     LOWERCASE  1: digits a-f (0x61-0x66); 0: digits A-F (0x41-0x46)
//
//   Ports
//     clk        clock, all state updates on posedge
//     rst        asynchronous active-high reset
//     bus        hex_char_formatter_if.slave (in_valid/in_ready/in_data/
//                in_mask, out_valid/out_ready/out_char/out_last, busy)
//
//   Build option
//     HEXFMT_NEWLINE_EN  when defined, each word is terminated by an extra
//                        8'h0A character which carries out_last; the last
//                        hex digit then has out_last=0.
// ---------------------------------------------------------------------------
module hex_char_formatter #(
    parameter int WIDTH     = 16,
    parameter bit LOWERCASE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    hex_char_formatter_if.slave  bus
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

`ifdef HEXFMT_NEWLINE_EN
    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_NL} state_t;
    localparam bit LAST_ON_DIGIT = 1'b0;
`else
    typedef enum logic [1:0] {S_IDLE, S_EMIT} state_t;
    localparam bit LAST_ON_DIGIT = 1'b1;
`endif

    state_t             state;
    logic [WIDTH-1:0]   word;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   cap_word;

    // ASCII code of one hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return (LOWERCASE ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
    endfunction

    // One mask bit per nibble widened to cover its four data bits.
    function automatic logic [WIDTH-1:0] expand_mask(input logic [NIB-1:0] m);
        logic [WIDTH-1:0] e;
        e = '0;
        for (int i = 0; i < NIB; i++)
            e[4*i +: 4] = {4{m[i]}};
        return e;
    endfunction

    function automatic logic [3:0] nib_at(input logic [WIDTH-1:0] w,
                                          input logic [IDX_W-1:0] i);
        return w[4*int'(i) +: 4];
    endfunction

    // Masking is applied once at capture so the stored word is already the
    // printable value and the mask input is free to change afterwards.
    assign cap_word = bus.in_data & ~expand_mask(bus.in_mask);

    assign bus.busy = ~bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            word          <= '0;
            idx           <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_char  <= 8'h00;
            bus.out_last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        // First character is produced straight from the
                        // captured value, giving one cycle of latency.
                        word          <= cap_word;
                        idx           <= IDX_W'(NIB - 1);
                        state         <= S_EMIT;
                        bus.in_ready  <= 1'b0;
                        bus.out_valid <= 1'b1;
                        bus.out_char  <= hex_ascii(cap_word[WIDTH-1 -: 4]);
                        bus.out_last  <= LAST_ON_DIGIT && (NIB == 1);
                    end
                end

                S_EMIT: begin
                    // out_valid is always 1 here, so out_ready alone marks
                    // the handshake.
                    if (bus.out_ready) begin
                        if (idx != '0) begin
                            idx          <= idx - 1'b1;
                            bus.out_char <= hex_ascii(nib_at(word, idx - 1'b1));
                            bus.out_last <= LAST_ON_DIGIT && (idx == IDX_W'(1));
                        end else begin
`ifdef HEXFMT_NEWLINE_EN
                            state        <= S_NL;
                            bus.out_char <= 8'h0A;
                            bus.out_last <= 1'b1;
`else
                            state         <= S_IDLE;
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            bus.in_ready  <= 1'b1;
`endif
                        end
                    end
                end

`ifdef HEXFMT_NEWLINE_EN
                S_NL: begin
                    if (bus.out_ready) begin
                        state         <= S_IDLE;
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                        bus.in_ready  <= 1'b1;
                    end
                end
`endif

                default: begin
                    state         <= S_IDLE;
                    bus.out_valid <= 1'b0;
                    bus.out_last  <= 1'b0;
                    bus.in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hex_char_formatter.sv
// ---------------------------------------------------------------------------
// tb_hex_char_formatter
//   Two formatters (lowercase and uppercase) share one stimulus. Directed
//   table vectors check exact cycle timing; hand sequences cover
//   backpressure, back-to-back words with in_valid held, and reset in the
//   middle of a word; a randomized phase compares against a reference
//   model with random out_ready.
// ---------------------------------------------------------------------------
module tb_hex_char_formatter;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;
`ifdef HEXFMT_NEWLINE_EN
    localparam int NL = 1;
`else
    localparam int NL = 0;
`endif
    localparam int C = NIB + NL;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic [3:0]  in_mask;
    logic        out_ready;

    always #5 clk = ~clk;

    hex_char_formatter_if #(.WIDTH(WIDTH)) lo_if ();
    hex_char_formatter_if #(.WIDTH(WIDTH)) up_if ();

    assign lo_if.in_valid  = in_valid;
    assign lo_if.in_data   = in_data;
    assign lo_if.in_mask   = in_mask;
    assign lo_if.out_ready = out_ready;
    assign up_if.in_valid  = in_valid;
    assign up_if.in_data   = in_data;
    assign up_if.in_mask   = in_mask;
    assign up_if.out_ready = out_ready;

    hex_char_formatter #(.WIDTH(WIDTH), .LOWERCASE(1'b1)) u_lo (
        .clk(clk), .rst(rst), .bus(lo_if)
    );
    hex_char_formatter #(.WIDTH(WIDTH), .LOWERCASE(1'b0)) u_up (
        .clk(clk), .rst(rst), .bus(up_if)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] q_lo[$];
    logic [8:0] q_up[$];

    typedef struct {
        logic [15:0] data;
        logic [3:0]  mask;
        logic [31:0] s_lo;
        logic [31:0] s_up;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: token k of a word is {last, ascii}; digits come from the
    // masked word, MS nibble first, then an optional newline.
    function automatic logic [8:0] exp_tok(input logic [15:0] d, input logic [3:0] m,
                                           input bit lower, input int k);
        int v;
        logic [7:0] c;
        if (k >= NIB) return {1'b1, 8'h0A};
        v = m[NIB-1-k] ? 0 : int'((d >> (4 * (NIB - 1 - k))) & 16'hf);
        c = (v < 10) ? 8'(48 + v) : 8'((lower ? 97 : 65) + v - 10);
        return {(k == NIB - 1) && (NL == 0), c};
    endfunction

    function automatic logic [8:0] tbl_tok(input logic [31:0] s, input int k);
        if (k >= NIB) return {1'b1, 8'h0A};
        return {(k == NIB - 1) && (NL == 0), s[8 * (NIB - 1 - k) +: 8]};
    endfunction

    task automatic check_tok(input string tag, input logic [8:0] el, input logic [8:0] eu);
        chk({tag, " lo valid"}, lo_if.out_valid, 1);
        chk({tag, " lo last/char"}, {lo_if.out_last, lo_if.out_char}, el);
        chk({tag, " up valid"}, up_if.out_valid, 1);
        chk({tag, " up last/char"}, {up_if.out_last, up_if.out_char}, eu);
        chk({tag, " in_ready busy"}, {lo_if.in_ready, up_if.in_ready, lo_if.busy, up_if.busy}, 4'b0011);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " idle valid"}, {lo_if.out_valid, up_if.out_valid}, 2'b00);
        chk({tag, " idle ready"}, {lo_if.in_ready, up_if.in_ready, lo_if.busy, up_if.busy}, 4'b1100);
    endtask

    task automatic wait_ready(input string tag);
        int t = 0;
        while (!(lo_if.in_ready && up_if.in_ready) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " ready wait"}, lo_if.in_ready & up_if.in_ready, 1);
    endtask

    // Presents one word at a negedge with out_ready=1 and checks every
    // character on consecutive cycles, then the single idle cycle.
    task automatic run_exact(input logic [15:0] d, input logic [3:0] m,
                             input logic [31:0] sl, input logic [31:0] su, input string tag);
        wait_ready(tag);
        in_valid  = 1'b1;
        in_data   = d;
        in_mask   = m;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_mask  = 4'($urandom);
        for (int k = 0; k < C; k++) begin
            @(negedge clk);
            check_tok($sformatf("%s c%0d", tag, k), tbl_tok(sl, k), tbl_tok(su, k));
        end
        @(negedge clk);
        check_idle(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t, limit 2000000", $time);
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        logic [3:0]  m;
        bit          done;

        vecs[0] = '{16'habcd, 4'b0000, "abcd", "ABCD"};
        vecs[1] = '{16'habcd, 4'b0010, "ab0d", "AB0D"};
        vecs[2] = '{16'habcd, 4'b1111, "0000", "0000"};
        vecs[3] = '{16'h1234, 4'b0000, "1234", "1234"};
        vecs[4] = '{16'hffff, 4'b0000, "ffff", "FFFF"};
        vecs[5] = '{16'h00ff, 4'b0000, "00ff", "00FF"};
        vecs[6] = '{16'h0000, 4'b0000, "0000", "0000"};
        vecs[7] = '{16'h5a9e, 4'b1000, "0a9e", "0A9E"};
        vecs[8] = '{16'h7e81, 4'b0110, "7001", "7001"};
        vecs[9] = '{16'h9c3b, 4'b0001, "9c30", "9C30"};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_mask   = 4'h0;
        out_ready = 1'b0;
        #12;
        chk("reset lo ready/busy", {lo_if.in_ready, lo_if.busy}, 2'b10);
        chk("reset up ready/busy", {up_if.in_ready, up_if.busy}, 2'b10);
        chk("reset lo valid/last", {lo_if.out_valid, lo_if.out_last}, 2'b00);
        chk("reset up valid/last", {up_if.out_valid, up_if.out_last}, 2'b00);
        chk("reset lo char", lo_if.out_char, 8'h00);
        chk("reset up char", up_if.out_char, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors, back to back with exact timing.
        for (int i = 0; i < 10; i++)
            run_exact(vecs[i].data, vecs[i].mask, vecs[i].s_lo, vecs[i].s_up,
                      $sformatf("vec%0d", i));

        // Backpressure: out_ready low for 3 cycles on the second character.
        wait_ready("bp");
        in_valid = 1'b1; in_data = 16'habcd; in_mask = 4'h0; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; in_data = 16'h1111;
        @(negedge clk);
        check_tok("bp c0", exp_tok(16'habcd, 0, 1, 0), exp_tok(16'habcd, 0, 0, 0));
        @(negedge clk);
        check_tok("bp c1", exp_tok(16'habcd, 0, 1, 1), exp_tok(16'habcd, 0, 0, 1));
        out_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            check_tok($sformatf("bp hold%0d", h), exp_tok(16'habcd, 0, 1, 1), exp_tok(16'habcd, 0, 0, 1));
        end
        out_ready = 1'b1;
        for (int k = 2; k < C; k++) begin
            @(negedge clk);
            check_tok($sformatf("bp c%0d", k), exp_tok(16'habcd, 0, 1, k), exp_tok(16'habcd, 0, 0, k));
        end
        @(negedge clk);
        check_idle("bp");

        // Back-to-back with in_valid held high: second word is held off
        // until the formatter is idle, giving exactly one idle cycle.
        wait_ready("b2b");
        in_valid = 1'b1; in_data = 16'h1234; in_mask = 4'h0; out_ready = 1'b1;
        @(posedge clk);
        #1 in_data = 16'hffff;
        for (int j = 0; j <= 2 * C + 1; j++) begin
            @(negedge clk);
            if (j < C)
                check_tok($sformatf("b2b w1 c%0d", j), exp_tok(16'h1234, 0, 1, j), exp_tok(16'h1234, 0, 0, j));
            else if (j == C || j == 2 * C + 1)
                check_idle($sformatf("b2b gap%0d", j));
            else
                check_tok($sformatf("b2b w2 c%0d", j - C - 1), exp_tok(16'hffff, 0, 1, j - C - 1),
                          exp_tok(16'hffff, 0, 0, j - C - 1));
            if (j == C + 1) in_valid = 1'b0;
        end

        // Reset after the second character of abcd.
        wait_ready("rst");
        in_valid = 1'b1; in_data = 16'habcd; in_mask = 4'h0; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check_tok("rst c0", exp_tok(16'habcd, 0, 1, 0), exp_tok(16'habcd, 0, 0, 0));
        @(negedge clk);
        check_tok("rst c1", exp_tok(16'habcd, 0, 1, 1), exp_tok(16'habcd, 0, 0, 1));
        #2 rst = 1'b1;
        #1;
        chk("rst async valid/last", {lo_if.out_valid, lo_if.out_last, up_if.out_valid, up_if.out_last}, 4'b0000);
        chk("rst async ready/busy", {lo_if.in_ready, lo_if.busy, up_if.in_ready, up_if.busy}, 4'b1010);
        @(negedge clk);
        rst = 1'b0;
        run_exact(16'h00ff, 4'h0, "00ff", "00FF", "after rst");

        // Randomized words with random out_ready against the model.
        done = 1'b0;
        fork
            begin
                logic [8:0] hold_lo, hold_up;
                bit held_lo, held_up;
                held_lo = 1'b0;
                held_up = 1'b0;
                hold_lo = '0;
                hold_up = '0;
                while (!done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (held_lo) begin
                        chk("hold lo valid", lo_if.out_valid, 1);
                        chk("hold lo last/char", {lo_if.out_last, lo_if.out_char}, hold_lo);
                    end
                    if (held_up) begin
                        chk("hold up valid", up_if.out_valid, 1);
                        chk("hold up last/char", {up_if.out_last, up_if.out_char}, hold_up);
                    end
                    chk("busy lo", lo_if.busy, !lo_if.in_ready);
                    if (lo_if.out_valid && out_ready) begin
                        if (q_lo.size() == 0) chk("lo unexpected char", q_lo.size(), 1);
                        else chk("rand lo last/char", {lo_if.out_last, lo_if.out_char}, q_lo.pop_front());
                    end
                    if (up_if.out_valid && out_ready) begin
                        if (q_up.size() == 0) chk("up unexpected char", q_up.size(), 1);
                        else chk("rand up last/char", {up_if.out_last, up_if.out_char}, q_up.pop_front());
                    end
                    held_lo = lo_if.out_valid && !out_ready;
                    held_up = up_if.out_valid && !out_ready;
                    hold_lo = {lo_if.out_last, lo_if.out_char};
                    hold_up = {up_if.out_last, up_if.out_char};
                end
            end
            begin
                int t;
                for (int w = 0; w < 40; w++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    wait_ready("rand");
                    d = 16'($urandom);
                    m = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                    for (int k = 0; k < C; k++) begin
                        q_lo.push_back(exp_tok(d, m, 1, k));
                        q_up.push_back(exp_tok(d, m, 0, k));
                    end
                    in_valid = 1'b1; in_data = d; in_mask = m;
                    @(posedge clk);
                    #1 in_valid = 1'b0; in_data = 16'($urandom); in_mask = 4'($urandom);
                end
                t = 0;
                while ((q_lo.size() != 0 || q_up.size() != 0) && t < 2000) begin
                    @(negedge clk);
                    t++;
                end
                chk("rand drain lo", q_lo.size(), 0);
                chk("rand drain up", q_up.size(), 0);
                done = 1'b1;
            end
        join
        out_ready = 1'b1;
        @(negedge clk);

        // Final word after the random phase still formats correctly.
        run_exact(16'hbeef, 4'b0100, "b0ef", "B0EF", "final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
